// File: rtl/select_next_hop_pkg.sv
// Shared definitions for the routing-table learner and the next-hop reader.
// Holds the data-memory map (byte addresses, 16-bit words), count clamps,
// the reader state encoding and a small saturating-clamp helper.
package select_next_hop_pkg;

  // Scalar table words
  localparam logic [15:0] NCNT_ADDR   = 16'h068A;  // stored neighborCount
  localparam logic [15:0] KSCNT_ADDR  = 16'h068C;  // learner's own sink-count word

  // Per-neighbor arrays, word stride 2 bytes
  localparam logic [15:0] NSCNT_BASE  = 16'h068E;  // per-neighbor sink count
  localparam logic [15:0] NID_BASE    = 16'h0048;  // neighborID
  localparam logic [15:0] CLU_BASE    = 16'h00C8;  // clusterID
  localparam logic [15:0] BAT_BASE    = 16'h0148;  // batteryStat
  localparam logic [15:0] Q_BASE      = 16'h01C8;  // qValue

  // Per-neighbor sinkID slot: MAX_SINKS words of 2 bytes each
  localparam logic [15:0] SID_BASE    = 16'h0248;
  localparam logic [15:0] SID_STRIDE  = 16'h0010;

  // Clamps applied to counts read back from memory
  localparam int MAX_NEIGHBORS = 128;
  localparam int MAX_SINKS     = 8;

  // Reader FSM encoding
  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_NCNT,
    S_CHK_N,
    S_RD_SCNT,
    S_CHK_S,
    S_RD_SID,
    S_RD_Q,
    S_RD_BAT,
    S_COMPARE,
    S_RD_ID,
    S_RD_CLU,
    S_DONE
  } hop_state_t;

  // Saturate a stored count to its clamp so a corrupted table cannot run away
  function automatic logic [15:0] clamp_count(input logic [15:0] v,
                                              input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/select_next_hop_compare.sv
// Candidate-vs-best comparator for next-hop selection.
// Purely combinational; unsigned compares on qValue then batteryStat.
// Strict "greater than" keeps the earlier (lower index) entry on a full tie.
module hop_compare #(
  parameter int WORD_WIDTH = 16
) (
  input  logic [WORD_WIDTH-1:0] cq,
  input  logic [WORD_WIDTH-1:0] cb,
  input  logic [WORD_WIDTH-1:0] best_q,
  input  logic [WORD_WIDTH-1:0] best_battery,
  input  logic                  valid,
  output logic                  win
);

  logic w_q_gt;
  logic w_q_eq;
  logic w_b_gt;

  // Candidate wins when nothing is held yet, on higher q, or on equal q with more battery
  always_comb begin
    w_q_gt = (cq > best_q);
    w_q_eq = (cq == best_q);
    w_b_gt = (cb > best_battery);
    win    = ~valid | w_q_gt | (w_q_eq & w_b_gt);
  end

endmodule

// File: rtl/select_next_hop.sv
// Walks the routing table in data memory and picks the best next hop for a sink.
// Each memory read takes two cycles (issue address, capture data_in next cycle).
// No backpressure: start is a level request; done holds until start drops.
module select_next_hop #(
  parameter int WORD_WIDTH    = 16,
  parameter int MAX_NEIGHBORS = select_next_hop_pkg::MAX_NEIGHBORS,
  parameter int MAX_SINKS     = select_next_hop_pkg::MAX_SINKS
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] fsinkID,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic [WORD_WIDTH-1:0] best_id,
  output logic [WORD_WIDTH-1:0] best_q,
  output logic [WORD_WIDTH-1:0] best_battery,
  output logic [WORD_WIDTH-1:0] best_cluster,
  output logic                  valid,
  output logic                  done
);

  import select_next_hop_pkg::*;

  localparam logic [WORD_WIDTH-1:0] LIM_N = WORD_WIDTH'(MAX_NEIGHBORS);
  localparam logic [WORD_WIDTH-1:0] LIM_S = WORD_WIDTH'(MAX_SINKS);

  // State and datapath registers
  hop_state_t            r_state;
  logic [WORD_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0] r_fsink;
  logic [WORD_WIDTH-1:0] r_n;
  logic [WORD_WIDTH-1:0] r_k;
  logic [WORD_WIDTH-1:0] r_ncnt;
  logic [WORD_WIDTH-1:0] r_scnt;
  logic [WORD_WIDTH-1:0] r_sid_base;
  logic [WORD_WIDTH-1:0] r_cq;
  logic [WORD_WIDTH-1:0] r_cb;
  logic [WORD_WIDTH-1:0] r_best_id;
  logic [WORD_WIDTH-1:0] r_best_q;
  logic [WORD_WIDTH-1:0] r_best_bat;
  logic [WORD_WIDTH-1:0] r_best_clu;
  logic                  r_valid;
  logic                  r_done;

  // Next-state values
  hop_state_t            w_state_nxt;
  logic [WORD_WIDTH-1:0] w_addr_nxt;
  logic [WORD_WIDTH-1:0] w_fsink_nxt;
  logic [WORD_WIDTH-1:0] w_n_nxt;
  logic [WORD_WIDTH-1:0] w_k_nxt;
  logic [WORD_WIDTH-1:0] w_ncnt_nxt;
  logic [WORD_WIDTH-1:0] w_scnt_nxt;
  logic [WORD_WIDTH-1:0] w_sid_base_nxt;
  logic [WORD_WIDTH-1:0] w_cq_nxt;
  logic [WORD_WIDTH-1:0] w_cb_nxt;
  logic [WORD_WIDTH-1:0] w_best_id_nxt;
  logic [WORD_WIDTH-1:0] w_best_q_nxt;
  logic [WORD_WIDTH-1:0] w_best_bat_nxt;
  logic [WORD_WIDTH-1:0] w_best_clu_nxt;
  logic                  w_valid_nxt;
  logic                  w_done_nxt;

  // Address offsets, all wrapping in 16 bits
  logic [WORD_WIDTH-1:0] w_n_x2;
  logic [WORD_WIDTH-1:0] w_k_x2;
  logic [WORD_WIDTH-1:0] w_n_sid;
  logic                  w_win;

  // Word offsets for the current neighbor and sink slot
  always_comb begin
    w_n_x2  = {r_n[WORD_WIDTH-2:0], 1'b0};
    w_k_x2  = {r_k[WORD_WIDTH-2:0], 1'b0};
    w_n_sid = r_n * SID_STRIDE;
  end

  hop_compare #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_hop_compare (
    .cq           (r_cq),
    .cb           (r_cb),
    .best_q       (r_best_q),
    .best_battery (r_best_bat),
    .valid        (r_valid),
    .win          (w_win)
  );

  // FSM state register; reset aborts any search in flight
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath update: one memory access per issue/capture pair
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_fsink_nxt    = r_fsink;
    w_n_nxt        = r_n;
    w_k_nxt        = r_k;
    w_ncnt_nxt     = r_ncnt;
    w_scnt_nxt     = r_scnt;
    w_sid_base_nxt = r_sid_base;
    w_cq_nxt       = r_cq;
    w_cb_nxt       = r_cb;
    w_best_id_nxt  = r_best_id;
    w_best_q_nxt   = r_best_q;
    w_best_bat_nxt = r_best_bat;
    w_best_clu_nxt = r_best_clu;
    w_valid_nxt    = r_valid;
    w_done_nxt     = r_done;

    case (r_state)
      S_IDLE: begin
        w_done_nxt = 1'b0;
        if (start) begin
          // Previous result is dropped only when a new search is accepted
          w_fsink_nxt    = fsinkID;
          w_best_id_nxt  = '0;
          w_best_q_nxt   = '0;
          w_best_bat_nxt = '0;
          w_best_clu_nxt = '0;
          w_valid_nxt    = 1'b0;
          w_n_nxt        = '0;
          w_addr_nxt     = NCNT_ADDR;
          w_state_nxt    = S_RD_NCNT;
        end
      end

      S_RD_NCNT: begin
        w_ncnt_nxt  = clamp_count(data_in, LIM_N);
        w_state_nxt = S_CHK_N;
      end

      S_CHK_N: begin
        if (r_n == r_ncnt) begin
          w_state_nxt = S_DONE;
        end else begin
          w_addr_nxt     = NSCNT_BASE + w_n_x2;
          w_sid_base_nxt = SID_BASE + w_n_sid;
          w_state_nxt    = S_RD_SCNT;
        end
      end

      S_RD_SCNT: begin
        w_scnt_nxt  = clamp_count(data_in, LIM_S);
        w_k_nxt     = '0;
        w_state_nxt = S_CHK_S;
      end

      S_CHK_S: begin
        if (r_k == r_scnt) begin
          // Sink list exhausted without a match: neighbor does not qualify
          w_n_nxt     = r_n + 1'b1;
          w_state_nxt = S_CHK_N;
        end else begin
          w_addr_nxt  = r_sid_base + w_k_x2;
          w_state_nxt = S_RD_SID;
        end
      end

      S_RD_SID: begin
        if (data_in == r_fsink) begin
          w_addr_nxt  = Q_BASE + w_n_x2;
          w_state_nxt = S_RD_Q;
        end else begin
          w_k_nxt     = r_k + 1'b1;
          w_state_nxt = S_CHK_S;
        end
      end

      S_RD_Q: begin
        w_cq_nxt    = data_in;
        w_addr_nxt  = BAT_BASE + w_n_x2;
        w_state_nxt = S_RD_BAT;
      end

      S_RD_BAT: begin
        w_cb_nxt    = data_in;
        w_state_nxt = S_COMPARE;
      end

      S_COMPARE: begin
        // ID and cluster are fetched only for a winner, saving reads on losers
        if (w_win) begin
          w_addr_nxt  = NID_BASE + w_n_x2;
          w_state_nxt = S_RD_ID;
        end else begin
          w_n_nxt     = r_n + 1'b1;
          w_state_nxt = S_CHK_N;
        end
      end

      S_RD_ID: begin
        w_best_id_nxt  = data_in;
        w_best_q_nxt   = r_cq;
        w_best_bat_nxt = r_cb;
        w_addr_nxt     = CLU_BASE + w_n_x2;
        w_state_nxt    = S_RD_CLU;
      end

      S_RD_CLU: begin
        w_best_clu_nxt = data_in;
        w_valid_nxt    = 1'b1;
        w_n_nxt        = r_n + 1'b1;
        w_state_nxt    = S_CHK_N;
      end

      S_DONE: begin
        w_done_nxt = 1'b1;
        if (!start) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath registers; everything clears on reset so no partial result survives
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      r_addr     <= '0;
      r_fsink    <= '0;
      r_n        <= '0;
      r_k        <= '0;
      r_ncnt     <= '0;
      r_scnt     <= '0;
      r_sid_base <= '0;
      r_cq       <= '0;
      r_cb       <= '0;
      r_best_id  <= '0;
      r_best_q   <= '0;
      r_best_bat <= '0;
      r_best_clu <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_addr     <= w_addr_nxt;
      r_fsink    <= w_fsink_nxt;
      r_n        <= w_n_nxt;
      r_k        <= w_k_nxt;
      r_ncnt     <= w_ncnt_nxt;
      r_scnt     <= w_scnt_nxt;
      r_sid_base <= w_sid_base_nxt;
      r_cq       <= w_cq_nxt;
      r_cb       <= w_cb_nxt;
      r_best_id  <= w_best_id_nxt;
      r_best_q   <= w_best_q_nxt;
      r_best_bat <= w_best_bat_nxt;
      r_best_clu <= w_best_clu_nxt;
      r_valid    <= w_valid_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Read-only client of the shared memory port
  always_comb begin
    address      = r_addr;
    wr_en        = 1'b0;
    data_out     = '0;
    best_id      = r_best_id;
    best_q       = r_best_q;
    best_battery = r_best_bat;
    best_cluster = r_best_clu;
    valid        = r_valid;
    done         = r_done;
  end

endmodule

// File: tb/tb_select_next_hop.sv
// Directed bench for select_next_hop with a combinational-read memory model.
// Covers reset, empty table, single match, sink filter, tie-break, clamps, mid-search reset.
module tb_select_next_hop;

  logic        clock = 1'b0;
  logic        nrst;
  logic        start;
  logic [15:0] fsinkID;
  logic [15:0] data_in;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] data_out;
  logic [15:0] best_id;
  logic [15:0] best_q;
  logic [15:0] best_battery;
  logic [15:0] best_cluster;
  logic        valid;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:1023];
  int          seen_stamp [0:1023];
  int          epoch = 0;

  always #5 clock = ~clock;

  // Memory answers in the cycle after the address register changes
  assign data_in = mem[address[10:1]];

  // Record every address the DUT presents during the current run
  always @(posedge clock) seen_stamp[address[10:1]] <= epoch;

  select_next_hop dut (
    .clock        (clock),
    .nrst         (nrst),
    .start        (start),
    .fsinkID      (fsinkID),
    .data_in      (data_in),
    .address      (address),
    .wr_en        (wr_en),
    .data_out     (data_out),
    .best_id      (best_id),
    .best_q       (best_q),
    .best_battery (best_battery),
    .best_cluster (best_cluster),
    .valid        (valid),
    .done         (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic was_seen(input logic [15:0] a);
    return seen_stamp[a[10:1]] == epoch;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mem[a[10:1]] = d;
  endtask

  // Launch a search, wiggle start/fsinkID mid-flight, wait for done, then release start
  task automatic run(input logic [15:0] sink, output int cyc);
    @(negedge clock);
    epoch++;
    start   = 1'b1;
    fsinkID = sink;
    cyc     = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      if (cyc == 2) fsinkID = ~sink;
      if (cyc == 5) start = 1'b0;
      if (cyc == 6) start = 1'b1;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
    start = 1'b0;
    for (int i = 0; i < 10 && done === 1'b1; i++) @(negedge clock);
    @(negedge clock);
  endtask

  task automatic load_tie();
    clear_mem();
    wr(16'h068A, 16'd3);
    for (int n = 0; n < 3; n++) begin
      wr(16'h068E + 16'(2*n), 16'd1);
      wr(16'h0248 + 16'(16*n), 16'h0005);
      wr(16'h01C8 + 16'(2*n), 16'h0040);
      wr(16'h0048 + 16'(2*n), 16'h00C0 + 16'(n));
      wr(16'h00C8 + 16'(2*n), 16'h0010 + 16'(n));
    end
    wr(16'h0148, 16'h0010);
    wr(16'h014A, 16'h0020);
    wr(16'h014C, 16'h0020);
  endtask

  initial begin
    int cyc;
    int stray;

    clear_mem();
    start   = 1'b0;
    fsinkID = 16'h0000;
    nrst    = 1'b1;
    #1 nrst = 1'b0;
    #1;
    chk("rst_address", address, 0);
    chk("rst_valid", valid, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_best_id", best_id, 0);
    repeat (2) @(negedge clock);
    nrst = 1'b1;

    // Empty table: done after 4 cycles, only neighborCount is read
    run(16'h0005, cyc);
    chk("empty_cycles", cyc, 4);
    chk("empty_valid", valid, 0);
    stray = 0;
    for (int i = 1; i < 1024; i++)
      if (seen_stamp[i] == epoch && i != (16'h068A >> 1)) stray++;
    chk("empty_only_ncnt", stray, 0);

    // Single qualifying neighbor
    clear_mem();
    wr(16'h068A, 16'd1);
    wr(16'h068E, 16'd1);
    wr(16'h0248, 16'h0005);
    wr(16'h01C8, 16'h0030);
    wr(16'h0148, 16'h0064);
    wr(16'h0048, 16'h00A1);
    wr(16'h00C8, 16'h0002);
    run(16'h0005, cyc);
    chk("single_id", best_id, 16'h00A1);
    chk("single_q", best_q, 16'h0030);
    chk("single_bat", best_battery, 16'h0064);
    chk("single_clu", best_cluster, 16'h0002);
    chk("single_valid", valid, 1);
    chk("single_wr_en", wr_en, 0);

    // Sink filter: high-q neighbor without the sink is skipped
    clear_mem();
    wr(16'h068A, 16'd2);
    wr(16'h068E, 16'd1);
    wr(16'h0248, 16'h0007);
    wr(16'h01C8, 16'h0090);
    wr(16'h0148, 16'h0050);
    wr(16'h0048, 16'h00B1);
    wr(16'h00C8, 16'h0001);
    wr(16'h0690, 16'd2);
    wr(16'h0258, 16'h0005);
    wr(16'h025A, 16'h0007);
    wr(16'h01CA, 16'h0010);
    wr(16'h014A, 16'h0033);
    wr(16'h004A, 16'h00B2);
    wr(16'h00CA, 16'h0003);
    run(16'h0005, cyc);
    chk("filter_id", best_id, 16'h00B2);
    chk("filter_q", best_q, 16'h0010);
    chk("filter_clu", best_cluster, 16'h0003);
    chk("filter_no_q0_read", {31'b0, was_seen(16'h01C8)}, 0);
    chk("filter_q1_read", {31'b0, was_seen(16'h01CA)}, 1);

    // Tie-break: battery decides, full tie keeps the lower index
    load_tie();
    run(16'h0005, cyc);
    chk("tie_id", best_id, 16'h00C1);
    chk("tie_bat", best_battery, 16'h0020);
    chk("tie_clu", best_cluster, 16'h0011);
    chk("tie_valid", valid, 1);

    // Clamps: 12 sinks read as 8, 0x200 neighbors read as 128
    clear_mem();
    wr(16'h068A, 16'h0200);
    wr(16'h068E, 16'h000C);
    for (int k = 0; k < 8; k++) wr(16'h0248 + 16'(2*k), 16'h0009);
    wr(16'h0258, 16'h0005);
    run(16'h0005, cyc);
    chk("clamp_last_sid", {31'b0, was_seen(16'h0256)}, 1);
    chk("clamp_no_sid8", {31'b0, was_seen(16'h0258)}, 0);
    chk("clamp_n127_read", {31'b0, was_seen(16'h078C)}, 1);
    chk("clamp_no_n128", {31'b0, was_seen(16'h078E)}, 0);
    chk("clamp_valid", valid, 0);

    // Reset while in RD_SID, then rerun the same table
    load_tie();
    @(negedge clock);
    start   = 1'b1;
    fsinkID = 16'h0005;
    for (int i = 0; i < 200 && address !== 16'h0248; i++) @(negedge clock);
    chk("mid_reach_sid", address, 16'h0248);
    nrst = 1'b0;
    #1;
    chk("mid_address", address, 0);
    chk("mid_valid", valid, 0);
    chk("mid_done", done, 0);
    chk("mid_best_id", best_id, 0);
    start = 1'b0;
    @(negedge clock);
    nrst = 1'b1;
    run(16'h0005, cyc);
    chk("rerun_id", best_id, 16'h00C1);
    chk("rerun_q", best_q, 16'h0040);
    chk("rerun_bat", best_battery, 16'h0020);
    chk("rerun_valid", valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/select_next_hop.md
Name: select_next_hop

Overview:
- Read-side counterpart of the routing-table learner: walks the per-node routing table in shared data memory and selects the best next hop toward a requested sink.
- Sits on the same 16-bit memory port as the learner, time-multiplexed by the controller. It never writes; `wr_en` is held 0.
- Result: the neighbor with the highest qValue whose sink list contains the requested sink. Ties go to the higher batteryStat, then to the lower neighbor index.

Parameters:
- WORD_WIDTH, 16, data/address width.
- MAX_NEIGHBORS, 128, upper clamp on the stored neighborCount.
- MAX_SINKS, 8, upper clamp on the per-neighbor sink count (16-byte sinkID slot).

Ports:
- clock  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  level request; sampled in IDLE.
- fsinkID  in  16  target sink ID; latched when start is accepted.
- data_in  in  16  memory read data; valid the cycle after `address` changes.
- address  out  16  byte address; registered.
- wr_en  out  1  constant 0.
- data_out  out  16  constant 0.
- best_id  out  16  selected neighborID.
- best_q  out  16  selected qValue.
- best_battery  out  16  selected batteryStat.
- best_cluster  out  16  selected clusterID.
- valid  out  1  1 = a qualifying neighbor was found.
- done  out  1  search complete; held until start is low.

Behaviour:
- Reset (asynchronous, nrst=0):
  - state=IDLE.
  - address, best_*, valid, done, wr_en, data_out all 0.
  - Internal n, k, counters cleared.
  - Reset mid-search aborts immediately; no partial result survives.
- Memory map (byte addresses, 16-bit words, stride 2):
  - neighborCount 0x68A.
  - neighborID 0x048+2n.
  - clusterID 0x0C8+2n.
  - batteryStat 0x148+2n.
  - qValue 0x1C8+2n.
  - sinkIDs 0x248+16n+2k.
  - per-neighbor sink count 0x68E+2n.
- Read timing: each read is two cycles. An issue state drives `address`; the next state captures `data_in`.
- States:
  - IDLE: done=0. If start=1: latch fsinkID, clear best_*/valid, n=0, address=0x68A, go RD_NCNT.
  - RD_NCNT: ncnt = min(data_in, MAX_NEIGHBORS); go CHK_N.
  - CHK_N: if n==ncnt go DONE. Else address=0x68E+2n, sid_base=0x248+16n, go RD_SCNT.
  - RD_SCNT: scnt = min(data_in, MAX_SINKS), k=0; go CHK_S.
  - CHK_S: if k==scnt, the neighbor does not qualify: n=n+1, go CHK_N. Else address=sid_base+2k, go RD_SID.
  - RD_SID: if data_in==fsinkID, address=0x1C8+2n, go RD_Q. Else k=k+1, go CHK_S.
  - RD_Q: cq=data_in; address=0x148+2n; go RD_BAT.
  - RD_BAT: cb=data_in; go COMPARE.
  - COMPARE: candidate wins if any of:
    - valid==0;
    - cq>best_q;
    - cq==best_q and cb>best_battery.
    - Comparisons are unsigned 16-bit.
    - Win: address=0x048+2n, go RD_ID. Lose: n=n+1, go CHK_N.
  - RD_ID: best_id=data_in, best_q=cq, best_battery=cb; address=0x0C8+2n; go RD_CLU.
  - RD_CLU: best_cluster=data_in, valid=1, n=n+1; go CHK_N.
  - DONE: done=1. Stay in DONE while start=1; go IDLE when start=0.
- Boundary conditions:
  - neighborCount=0 gives done with valid=0 after 4 cycles from start.
  - scnt=0 disqualifies that neighbor.
  - Stored counts above the clamps are truncated to the clamp value.
  - Equal qValue and equal battery: the first (lower n) neighbor is kept.
  - best_* hold their values through DONE and until the next accepted start.
  - start toggling during a search is ignored.
  - fsinkID changes after acceptance are ignored.
- Arithmetic: address offsets are computed in 16 bits. n and k counters are 16-bit.

Decomposition:
- Shared package (used by learner and reader):
  - memory-map base constants: NCNT_ADDR, KSCNT_ADDR, NSCNT_BASE, NID_BASE, CLU_BASE, BAT_BASE, Q_BASE, SID_BASE, SID_STRIDE;
  - MAX_NEIGHBORS and MAX_SINKS;
  - state encoding enum.
- Sub-module hop_compare: combinational candidate-vs-best comparator; inputs cq, cb, best_q, best_battery, valid; output win.

Test Plan:
- Empty table: neighborCount=0, start=1 -> done=1 at cycle 4, valid=0, all address reads only 0x68A.
- Single match:
  - Setup: ncnt=1; n0 sinks {0x0005}; q=0x0030; bat=0x0064; id=0x00A1; clu=0x0002; fsinkID=0x0005.
  - Expect: best_id=0x00A1, best_q=0x0030, best_battery=0x0064, best_cluster=0x0002, valid=1.
- Sink filter:
  - Setup: n0 has q=0x0090 with sinks {0x0007}; n1 has q=0x0010 with sinks {0x0005,0x0007}; fsinkID=0x0005.
  - Expect: best_id = n1's ID, and n0's qValue address 0x1C8 is never issued.
- Tie-break:
  - Setup: three matches. n0 q=0x40/bat=0x10; n1 q=0x40/bat=0x20; n2 q=0x40/bat=0x20.
  - Expect: the selected entry is n1.
- Clamp: n0 sink count stored 0x000C -> sinkID reads stop after address 0x248+14; no read of 0x248+16.
- Reset mid-search: nrst=0 during RD_SID -> same delta: state IDLE, valid=0, done=0, address=0. A subsequent start reruns cleanly with an identical result.
